// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath front end.
// Contents:
//   mem_state_e : memory-port handshake FSM states
//   acc_kind_e  : what an in-flight access commits into (IR, MDR, or nothing for stores)
//   OP_*        : primary opcode constants decoded by the controller from IR[31:26]
//   word_aligned: true when a byte address is on a 32-bit word boundary
package mips_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RD = 2'd1,
    ST_WAIT_WR = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    KIND_IR  = 2'd0,
    KIND_MDR = 2'd1,
    KIND_ST  = 2'd2
  } acc_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mc_fetch_mem_unit_if.sv
// Shared instruction/data memory port of the multicycle core.
// Signals:
//   mem_req   : access valid, held until mem_ready
//   mem_we    : write strobe, valid with mem_req
//   mem_addr  : byte address of the word being accessed
//   mem_wdata : store data
//   mem_rdata : read data, valid with mem_ready
//   mem_ready : access completes this cycle
// master = the fetch/mem unit, slave = the memory.
interface mc_fetch_mem_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_mem_port.sv
// Request/ready handshake engine for the shared memory port.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : launch a legal access (only looked at while idle)
//   we, addr, wdata   : access type, address and store data captured at start
//   ready             : memory completes the access this cycle
//   req, req_we,
//   req_addr, req_wdata : registered request toward memory
//   busy              : an access is outstanding (FSM not idle)
//   done              : access completes this cycle (busy & ready)
//   err               : access is abandoned this cycle after TIMEOUT waiting cycles
module mc_mem_port
  import mips_mc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ready,
  output logic        req,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  mem_state_e    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          req_reg;
  logic          we_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;

  assign busy = (state_reg != ST_IDLE);
  assign done = busy & ready;
  // cnt_reg counts completed waiting cycles, so the request is held for
  // exactly TIMEOUT cycles before being dropped.
  assign err  = busy & ~ready & (cnt_reg >= CNT_LAST);

  assign req       = req_reg;
  assign req_we    = we_reg;
  assign req_addr  = addr_reg;
  assign req_wdata = wdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= we ? ST_WAIT_WR : ST_WAIT_RD;
            req_reg   <= 1'b1;
            we_reg    <= we;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            cnt_reg   <= '0;
          end
        end
        default: begin
          if (done || err) begin
            state_reg <= ST_IDLE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            cnt_reg   <= '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mc_fetch_mem_unit.sv
// Datapath front end of the multicycle MIPS core: PC, IR and MDR plus the
// shared memory port.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   ir_write        : fetch, load IR from memory at address PC/alu_out
//   pc_write, branch, zero, pc_src, alu_result, alu_out : PC update control
//   iord            : 0 address = PC, 1 address = alu_out
//   mem_rd          : data load into MDR
//   mem_write       : store of b_reg
//   b_reg           : store data
//   mem             : memory port (master side)
//   stall           : controller must hold its state
//   opcode, instr   : IR[31:26] and full IR
//   pc, mdr         : current PC, last loaded data word
//   bus_err         : sticky timeout / misalignment / multi-request flag
module mc_fetch_mem_unit
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ir_write,
  input  logic                       pc_write,
  input  logic                       branch,
  input  logic                       pc_src,
  input  logic                       iord,
  input  logic                       mem_rd,
  input  logic                       mem_write,
  input  logic [31:0]                alu_result,
  input  logic [31:0]                alu_out,
  input  logic                       zero,
  input  logic [31:0]                b_reg,
  mc_fetch_mem_unit_if.master        mem,
  output logic                       stall,
  output logic [5:0]                 opcode,
  output logic [31:0]                instr,
  output logic [31:0]                pc,
  output logic                       mdr_unused_guard,
  output logic [31:0]                mdr,
  output logic                       bus_err
);

  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] mdr_reg;
  logic        bus_err_reg;
  acc_kind_e   kind_reg;
  logic        pend_take_reg;
  logic [31:0] pend_target_reg;

  logic        start_any;
  logic        multi;
  logic [31:0] addr_sel;
  logic        legal;
  logic        take;
  logic [31:0] target;
  logic        busy;
  logic        done;
  logic        err;

  assign start_any = ir_write | mem_rd | mem_write;
  assign multi     = (ir_write & mem_rd) | (ir_write & mem_write) | (mem_rd & mem_write);
  assign addr_sel  = iord ? alu_out : pc_reg;
  assign legal     = start_any & ~multi & word_aligned(addr_sel);
  assign take      = pc_write | (branch & zero);
  assign target    = pc_src ? alu_out : alu_result;

  mc_mem_port #(.TIMEOUT(TIMEOUT)) u_port (
    .clk       (clk),
    .rst       (rst),
    .start     (legal),
    .we        (mem_write),
    .addr      (addr_sel),
    .wdata     (b_reg),
    .ready     (mem.mem_ready),
    .req       (mem.mem_req),
    .req_we    (mem.mem_we),
    .req_addr  (mem.mem_addr),
    .req_wdata (mem.mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign stall  = (~busy & legal) | (busy & ~mem.mem_ready);
  assign opcode = ir_reg[31:26];
  assign instr  = ir_reg;
  assign pc     = pc_reg;
  assign mdr    = mdr_reg;
  assign bus_err = bus_err_reg;
  assign mdr_unused_guard = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      ir_reg          <= '0;
      mdr_reg         <= '0;
      bus_err_reg     <= 1'b0;
      kind_reg        <= KIND_IR;
      pend_take_reg   <= 1'b0;
      pend_target_reg <= '0;
    end else if (!busy) begin
      if (start_any && !legal) begin
        // Illegal request: nothing issued, nothing updated except the flag.
        bus_err_reg <= 1'b1;
      end else if (legal) begin
        // PC update is deferred to the completion so it happens once per access.
        kind_reg        <= ir_write ? KIND_IR : (mem_rd ? KIND_MDR : KIND_ST);
        pend_take_reg   <= take;
        pend_target_reg <= target;
      end else if (take) begin
        pc_reg <= target;
      end
    end else if (done) begin
      if (kind_reg == KIND_IR)  ir_reg  <= mem.mem_rdata;
      if (kind_reg == KIND_MDR) mdr_reg <= mem.mem_rdata;
      if (pend_take_reg)        pc_reg  <= pend_target_reg;
    end else if (err) begin
      // Timed-out access: no commit, pending PC update dropped.
      bus_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_fetch_mem_unit.sv
// Directed self-checking bench for mc_fetch_mem_unit.
module tb_mc_fetch_mem_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ir_write, pc_write, branch, pc_src, iord, mem_rd, mem_write, zero;
  logic [31:0] alu_result, alu_out, b_reg;
  logic        stall, bus_err, guard;
  logic [5:0]  opcode;
  logic [31:0] instr, pc, mdr;

  int checks   = 0;
  int failures = 0;
  int n;

  mc_fetch_mem_unit_if mif();

  mc_fetch_mem_unit #(.RESET_PC(32'h0040_0000), .TIMEOUT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .branch           (branch),
    .pc_src           (pc_src),
    .iord             (iord),
    .mem_rd           (mem_rd),
    .mem_write        (mem_write),
    .alu_result       (alu_result),
    .alu_out          (alu_out),
    .zero             (zero),
    .b_reg            (b_reg),
    .mem              (mif.master),
    .stall            (stall),
    .opcode           (opcode),
    .instr            (instr),
    .pc               (pc),
    .mdr_unused_guard (guard),
    .mdr              (mdr),
    .bus_err          (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-14s obs=0x%08h exp=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir_write = 0; pc_write = 0; branch = 0; pc_src = 0; iord = 0;
    mem_rd = 0; mem_write = 0; zero = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    alu_result = 0; alu_out = 0; b_reg = 0;
    mif.mem_ready = 0; mif.mem_rdata = 0;
    rst = 1;
    tick(); tick();
    rst = 0;

    // 1. Reset state
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_instr", instr, 32'h0);
    check("rst_mem_req", {31'b0, mif.mem_req}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);

    // 2. Fetch with 3 wait cycles
    ir_write = 1; pc_write = 1; alu_result = 32'h0040_0004;
    #1 n = stall ? 1 : 0;
    tick();
    idle_inputs(); alu_result = 32'hFFFF_FFF0;   // ignored while waiting
    check("f_mem_addr", mif.mem_addr, 32'h0040_0000);
    check("f_mem_req", {31'b0, mif.mem_req}, 32'h1);
    check("f_pc_hold", pc, 32'h0040_0000);
    for (int i = 0; i < 3; i++) begin
      if (stall) n++;
      tick();
    end
    check("f_pc_hold2", pc, 32'h0040_0000);
    mif.mem_ready = 1; mif.mem_rdata = 32'h8C08_0004;
    #1 if (stall) n++;
    check("f_stall_cnt", n, 4);
    tick();
    mif.mem_ready = 0; mif.mem_rdata = 0;
    check("f_instr", instr, 32'h8C08_0004);
    check("f_opcode", {26'b0, opcode}, 32'h23);
    check("f_pc", pc, 32'h0040_0004);
    check("f_req_drop", {31'b0, mif.mem_req}, 32'h0);

    // 3. Load, zero waits
    mem_rd = 1; iord = 1; alu_out = 32'h0000_1000;
    #1 check("l_stall_start", {31'b0, stall}, 32'h1);
    tick();
    idle_inputs();
    check("l_mem_addr", mif.mem_addr, 32'h0000_1000);
    check("l_mem_we", {31'b0, mif.mem_we}, 32'h0);
    mif.mem_ready = 1; mif.mem_rdata = 32'hDEAD_BEEF;
    #1 check("l_stall_ready", {31'b0, stall}, 32'h0);
    tick();
    mif.mem_ready = 0; mif.mem_rdata = 0;
    check("l_mdr", mdr, 32'hDEAD_BEEF);
    check("l_instr", instr, 32'h8C08_0004);
    check("l_pc", pc, 32'h0040_0004);

    // 4a. Store with one wait cycle
    mem_write = 1; iord = 1; alu_out = 32'h0000_2004; b_reg = 32'h1234_5678;
    tick();
    idle_inputs(); b_reg = 32'h0;
    check("s_mem_we", {31'b0, mif.mem_we}, 32'h1);
    check("s_mem_addr", mif.mem_addr, 32'h0000_2004);
    check("s_wdata", mif.mem_wdata, 32'h1234_5678);
    tick();
    check("s_wdata_hold", mif.mem_wdata, 32'h1234_5678);
    mif.mem_ready = 1;
    tick();
    mif.mem_ready = 0;
    check("s_req_drop", {31'b0, mif.mem_req}, 32'h0);
    check("s_mdr_keep", mdr, 32'hDEAD_BEEF);

    // 4b. Branch not taken, then taken
    branch = 1; zero = 0; pc_src = 1; alu_out = 32'h0040_0020;
    tick();
    check("b_nt_pc", pc, 32'h0040_0004);
    zero = 1;
    #1 check("b_t_stall", {31'b0, stall}, 32'h0);
    tick();
    idle_inputs();
    check("b_t_pc", pc, 32'h0040_0020);

    // 5a. Timeout
    ir_write = 1; pc_write = 1; alu_result = 32'h0040_0024;
    tick();
    idle_inputs();
    n = 0;
    while (mif.mem_req && n < 40) begin
      tick();
      n++;
    end
    check("t_req_cycles", n, 16);
    check("t_bus_err", {31'b0, bus_err}, 32'h1);
    check("t_instr", instr, 32'h8C08_0004);
    check("t_pc", pc, 32'h0040_0020);

    // 5b. Misaligned load
    do_reset();
    check("m_rst_err", {31'b0, bus_err}, 32'h0);
    mem_rd = 1; iord = 1; alu_out = 32'h0000_1002;
    #1 check("m_stall", {31'b0, stall}, 32'h0);
    tick();
    idle_inputs();
    check("m_mem_req", {31'b0, mif.mem_req}, 32'h0);
    check("m_bus_err", {31'b0, bus_err}, 32'h1);

    // 5c. Two requests at once
    do_reset();
    ir_write = 1; mem_rd = 1;
    #1 check("x_stall", {31'b0, stall}, 32'h0);
    tick();
    idle_inputs();
    check("x_mem_req", {31'b0, mif.mem_req}, 32'h0);
    check("x_bus_err", {31'b0, bus_err}, 32'h1);

    // 6. Reset during WAIT_RD with ready in the same cycle
    do_reset();
    ir_write = 1; pc_write = 1; alu_result = 32'h0040_0004;
    tick();
    idle_inputs();
    tick();
    rst = 1; mif.mem_ready = 1; mif.mem_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 0; mif.mem_ready = 0; mif.mem_rdata = 0;
    check("r_mem_req", {31'b0, mif.mem_req}, 32'h0);
    check("r_instr", instr, 32'h0);
    check("r_pc", pc, 32'h0040_0000);
    check("r_bus_err", {31'b0, bus_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
